// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares a single-ported backing-memory bus between the instruction-fetch
// port and the data port. It arbitrates round-robin on ties and runs one
// memory transaction at a time. Completion is a one-cycle ready pulse on the
// port that owns the transaction. A bounded-wait timeout aborts a transaction
// when the memory never acks.
//
// Ports
//   clk_i, rst_i          clock (rising edge), async active-low reset
//   ins_req_i/addr_i      instruction read request and word address
//   ins_rdata_o/ready_o   instruction read data and completion pulse
//   ins_err_o             completion was a timeout abort
//   data_req_i/addr_i     data request and word address
//   data_we_i/wdata_i     byte write enables (0 = read) and write data
//   data_rdata_o/ready_o  data read data and completion pulse
//   data_err_o            completion was a timeout abort
//   mem_req_o..wdata_o    memory request, held until ack or abort
//   mem_rdata_i/ack_i     memory read data with its single-cycle ack
//   timeout_o             sticky flag: some transaction timed out
//
// state  | meaning
// IDLE   | waiting for a request; mem_ack_i ignored
// BUSY_I | instruction transaction on the memory bus
// BUSY_D | data transaction on the memory bus
// RESP   | one-cycle ready pulse to the owning port

module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ins_req_i,
  input  logic [29:0] ins_addr_i,
  output logic [31:0] ins_rdata_o,
  output logic        ins_ready_o,
  output logic        ins_err_o,
  input  logic        data_req_i,
  input  logic [29:0] data_addr_i,
  input  logic [3:0]  data_we_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_ready_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic [29:0] mem_addr_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;

  // Abort fires on the last allowed BUSY cycle. When TIMEOUT_CYCLES is 0 this
  // constant wraps, but it is never used because the timeout is disabled.
  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);

  state_e          state_q, state_d;
  logic            last_d_q, last_d_d;   // 1: last grant went to the data port
  logic            resp_d_q, resp_d_d;   // 1: current RESP belongs to data port
  logic            err_q, err_d;
  logic            to_q, to_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [29:0]     addr_q, addr_d;
  logic [3:0]      we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     ins_rdata_q, ins_rdata_d;
  logic [31:0]     data_rdata_q, data_rdata_d;
  logic            busy;
  logic            to_hit;

  assign busy   = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign to_hit = TO_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      last_d_q     <= 1'b1;
      resp_d_q     <= 1'b0;
      err_q        <= 1'b0;
      to_q         <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      we_q         <= '0;
      wdata_q      <= '0;
      ins_rdata_q  <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_d_q     <= last_d_d;
      resp_d_q     <= resp_d_d;
      err_q        <= err_d;
      to_q         <= to_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      ins_rdata_q  <= ins_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d_d     = last_d_q;
    resp_d_d     = resp_d_q;
    err_d        = err_q;
    to_d         = to_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    ins_rdata_d  = ins_rdata_q;
    data_rdata_d = data_rdata_q;

    case (state_q)
      IDLE: begin
        // Instruction wins when alone, or on a tie when data went last.
        if (ins_req_i && (!data_req_i || last_d_q)) begin
          state_d  = BUSY_I;
          last_d_d = 1'b0;
          addr_d   = ins_addr_i;
          we_d     = '0;
          wdata_d  = '0;
          cnt_d    = '0;
        end else if (data_req_i) begin
          state_d  = BUSY_D;
          last_d_d = 1'b1;
          addr_d   = data_addr_i;
          we_d     = data_we_i;
          wdata_d  = data_wdata_i;
          cnt_d    = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        // An ack on the abort cycle still completes normally.
        if (mem_ack_i) begin
          state_d  = RESP;
          err_d    = 1'b0;
          resp_d_d = (state_q == BUSY_D);
          if (state_q == BUSY_D) data_rdata_d = mem_rdata_i;
          else                   ins_rdata_d  = mem_rdata_i;
        end else if (to_hit) begin
          state_d  = RESP;
          err_d    = 1'b1;
          to_d     = 1'b1;
          resp_d_d = (state_q == BUSY_D);
          if (state_q == BUSY_D) data_rdata_d = '0;
          else                   ins_rdata_d  = '0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus outputs are decoded from state so reset removes the request at once.
  assign mem_req_o    = busy;
  assign mem_addr_o   = busy ? addr_q  : '0;
  assign mem_we_o     = busy ? we_q    : '0;
  assign mem_wdata_o  = busy ? wdata_q : '0;

  assign ins_ready_o  = (state_q == RESP) && !resp_d_q;
  assign data_ready_o = (state_q == RESP) &&  resp_d_q;
  assign ins_err_o    = ins_ready_o  && err_q;
  assign data_err_o   = data_ready_o && err_q;
  assign ins_rdata_o  = ins_rdata_q;
  assign data_rdata_o = data_rdata_q;
  assign timeout_o    = to_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported backing-memory bus between the core's instruction-fetch port and its data port. It arbitrates round-robin between the two, drives one memory transaction at a time, and returns read data with a one-cycle ready pulse. A bounded-wait timeout aborts hung transactions. It sits between the core's cache-side ports and the memory/bus adapter.

Parameters:
TIMEOUT_CYCLES, 255, number of BUSY cycles without mem_ack_i before the transaction aborts; 0 disables the timeout.
TO_W, 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**TO_W.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
ins_req_i  input  1  instruction read request, held high until ins_ready_o
ins_addr_i  input  30  word address [31:2]
ins_rdata_o  output  32  instruction read data, valid while ins_ready_o is high
ins_ready_o  output  1  one-cycle completion pulse
ins_err_o  output  1  high with ins_ready_o when the transaction timed out
data_req_i  input  1  data request, held high until data_ready_o
data_addr_i  input  30  word address [31:2]
data_we_i  input  4  byte write enables; 0 = read
data_wdata_i  input  32  write data
data_rdata_o  output  32  data read data, valid while data_ready_o is high
data_ready_o  output  1  one-cycle completion pulse
data_err_o  output  1  high with data_ready_o on timeout
mem_req_o  output  1  memory request, held until ack
mem_addr_o  output  30  memory word address
mem_we_o  output  4  memory byte enables
mem_wdata_o  output  32  memory write data
mem_rdata_i  input  32  memory read data, valid with mem_ack_i
mem_ack_i  input  1  memory completion, single cycle
timeout_o  output  1  sticky: a timeout occurred since reset

Behaviour:
- Reset (rst_i = 0, asynchronous) sets state = IDLE, all outputs = 0, last_grant = DATA, and the timeout counter = 0. It takes effect immediately, including mid-transaction; mem_req_o drops without waiting for a clock edge.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE, only one request high: grant it.
  - IDLE, both requests high: grant the port opposite last_grant, then update last_grant.
  - On a grant, latch addr, we and wdata into registers (we = 0 for instruction) and move to BUSY_x.
  - In IDLE, mem_ack_i is ignored.
- BUSY_x:
  - mem_req_o = 1.
  - mem_addr_o, mem_we_o and mem_wdata_o come from the latched registers and stay stable until ack or abort.
  - Requester inputs are ignored while in BUSY_x.
  - On a mem_ack_i cycle, register mem_rdata_i into that port's rdata (for writes, capture as-is) and go to RESP.
- Timeout (TIMEOUT_CYCLES > 0):
  - The counter increments on each BUSY cycle without ack and clears on entering BUSY.
  - When counter == TIMEOUT_CYCLES - 1 with no ack, abort: go to RESP with err set, rdata = 0, timeout_o = 1 (sticky).
  - An ack in the same cycle as the abort condition wins: normal completion, no error.
- RESP:
  - mem_req_o = 0.
  - Exactly one of ins_ready_o / data_ready_o is high; the matching err_o reflects timeout.
  - rdata holds its value. Requests are not sampled. Next state = IDLE.
- Requester rule: drop req in the cycle after ready. A req still high in the following IDLE cycle is treated as a new request.
- Latency with zero-wait memory:
  - req high at cycle 0 → mem_req_o high at cycle 1; ack at cycle 1 → ready at cycle 2; next grant possible at cycle 3.
  - Throughput: one transaction per 3 cycles minimum.
- mem_ack_i arriving in RESP or IDLE (a late ack after an abort) is ignored and has no effect on state or rdata.
- rdata outputs keep their last value outside RESP (not cleared).

Test Plan:
- Instruction read: ins_req_i = 1, ins_addr_i = 30'h0000_0040, memory acks at cycle 2 with rdata 32'h0000_0013 → mem_addr_o = 30'h40 and mem_we_o = 0 during cycles 1-2; ins_ready_o pulses at cycle 3 with ins_rdata_o = 32'h13; ins_err_o = 0.
- Data write: data_we_i = 4'b0011, data_wdata_i = 32'hDEADBEEF, addr 30'h100; ack delayed 5 cycles → mem_* stay stable on all 5 wait cycles, single data_ready_o pulse, ins port untouched.
- Both ports requesting continuously for 4 transactions from reset → grant order I, D, I, D; no grant ever overlaps another.
- TIMEOUT_CYCLES = 4 with no ack → mem_req_o high for exactly 4 cycles, then data_ready_o = 1 with data_err_o = 1 and data_rdata_o = 0, timeout_o = 1 and it stays 1; a late ack 2 cycles later is ignored.
- Assert rst_i low mid-BUSY_D → mem_req_o = 0 immediately (asynchronously). After release, a tie grants instruction first; timeout_o = 0.
- Ack on the same cycle as the timeout condition → normal completion, err_o = 0, timeout_o unchanged.
